mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 4-to-1 bus multiplexer. Four requesters compete for one downstream channel. The block grants one requester at a time, drives the two mux select lines, and presents the selected requester's data with a valid/ready handshake. It holds the grant across a burst and rotates priority fairly after each release.

---
 rtl/mux4_rr_arbiter_if.sv | 27 ++
 rtl/mux4_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/downstream bundle for the 4-to-1 round-robin bus arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 4
) ();
  logic [3:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] data3;
  logic             out_ready;
  logic [3:0]       gnt;
  logic             s1;
  logic             s0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  req, data0, data1, data2, data3, out_ready,
    output gnt, s1, s0, out_valid, out_data
  );

  modport master (
    output req, data0, data1, data2, data3, out_ready,
    input  gnt, s1, s0, out_valid, out_data
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4-to-1 bus mux; holds the grant per burst.
// Optional burst limit (MAX_BURST beats per grant) via MUX4_ARB_BURST_LIMIT_EN.
//
// state | meaning
// IDLE  | turnaround cycle, no grant; arbitrate among pending requests
// GRANT | one requester owns the mux until its req drops (or burst limit)
module mux4_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux4_rr_arbiter_if.slave      bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       win_idx;
  logic             win_found;
  logic             sel_req;
  logic             release_grant;
  logic [WIDTH-1:0] sel_data;

  if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_max_burst_range
    $error("MAX_BURST must be within 1..256");
  end

`ifdef MUX4_ARB_BURST_LIMIT_EN
  localparam logic [7:0] BEAT_LAST = 8'(MAX_BURST - 1);
  logic [7:0] beat_q, beat_d;
  logic       beat;
`endif

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      if (!win_found && bus.req[2'(last_q + 2'(k))]) begin
        win_found = 1'b1;
        win_idx   = 2'(last_q + 2'(k));
      end
    end
  end

  assign sel_req = bus.req[sel_q];

  always_comb begin
    case (sel_q)
      2'd0:    sel_data = bus.data0;
      2'd1:    sel_data = bus.data1;
      2'd2:    sel_data = bus.data2;
      default: sel_data = bus.data3;
    endcase
  end

  assign bus.out_valid = (state_q == GRANT) && sel_req;
  assign bus.out_data  = bus.out_valid ? sel_data : '0;
  assign bus.gnt       = gnt_q;
  assign bus.s1        = sel_q[1];
  assign bus.s0        = sel_q[0];

`ifdef MUX4_ARB_BURST_LIMIT_EN
  assign beat          = bus.out_valid && bus.out_ready;
  assign release_grant = !sel_req || (beat && (beat_q == BEAT_LAST));
`else
  assign release_grant = !sel_req;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
`ifdef MUX4_ARB_BURST_LIMIT_EN
    beat_d  = beat_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          last_d  = win_idx;
          sel_d   = win_idx;
          gnt_d   = 4'b0001 << win_idx;
`ifdef MUX4_ARB_BURST_LIMIT_EN
          beat_d  = 8'd0;
`endif
        end
      end
      GRANT: begin
`ifdef MUX4_ARB_BURST_LIMIT_EN
        if (beat) beat_d = beat_q + 8'd1;
`endif
        if (release_grant) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          sel_d   = 2'd0;
        end
      end
    endcase
  end

  // last resets to 3 so requester 0 wins the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
`ifdef MUX4_ARB_BURST_LIMIT_EN
      beat_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
`ifdef MUX4_ARB_BURST_LIMIT_EN
      beat_q  <= beat_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: vector table plus hand-written burst/reset sequences.
module tb_mux4_rr_arbiter;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       vld;
    logic [3:0] data;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   xfers;
  vec_t vecs[$];
  logic [3:0] dv [4];

  mux4_rr_arbiter_if #(.WIDTH(4)) bus ();

  mux4_rr_arbiter #(.WIDTH(4), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) xfers++;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "time limit reached");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] egnt, input logic [1:0] esel,
                         input logic evld, input logic [3:0] edata);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(egnt));
    if (egnt != 4'b0000) chk({tag, ".sel"}, 32'({bus.s1, bus.s0}), 32'(esel));
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(evld));
    chk({tag, ".data"}, 32'(bus.out_data), 32'(edata));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic [3:0] r, logic y, logic [3:0] g, logic [1:0] s,
                              logic v, logic [3:0] d);
    vec_t t;
    t.req = r; t.rdy = y; t.gnt = g; t.sel = s; t.vld = v; t.data = d;
    return t;
  endfunction

  initial begin
    int exp_xfers;
    checks   = 0;
    failures = 0;
    xfers    = 0;
    dv[0] = 4'h5; dv[1] = 4'hA; dv[2] = 4'hC; dv[3] = 4'h3;

    // Rotation: fresh pointer, all four requesting, each drops after one beat.
    vecs.push_back(mk(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 4'h0));
    for (int n = 0; n < 5; n++) begin
      int i;
      i = n % 4;
      vecs.push_back(mk(4'b1111, 1'b1, 4'(1 << i), 2'(i), 1'b1, dv[i]));
      vecs.push_back(mk(4'b1111 & ~4'(1 << i), 1'b1, 4'(1 << i), 2'(i), 1'b0, 4'h0));
      if (n < 4) vecs.push_back(mk(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 4'h0));
    end
    // Data path with back-pressure, then mid-burst drop of requester 2.
    vecs.push_back(mk(4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 4'h0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'hC));
    vecs.push_back(mk(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 4'hC));
    vecs.push_back(mk(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 4'hC));
    vecs.push_back(mk(4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, 4'h0));
    vecs.push_back(mk(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'h0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'h0));

    bus.data0 = dv[0]; bus.data1 = dv[1]; bus.data2 = dv[2]; bus.data3 = dv[3];
    bus.req = 4'b0000;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;

    // Held in reset with requests toggling: nothing may be granted.
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.req = (k % 2 == 0) ? 4'b1111 : 4'b0000;
      #1;
      chk_out("reset_hold", 4'b0000, 2'd0, 1'b0, 4'h0);
      chk("reset_sel", 32'({bus.s1, bus.s0}), 32'd0);
    end
    tick();
    bus.req = 4'b1111;
    rst_n = 1'b1;

    for (int v = 0; v < vecs.size(); v++) begin
      bus.req       = vecs[v].req;
      bus.out_ready = vecs[v].rdy;
      #1;
      chk_out($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].sel, vecs[v].vld, vecs[v].data);
      tick();
    end
    chk("xfers_table", 32'(xfers), 32'd7);

    // Burst behaviour: requesters 0 and 1 both holding req.
    bus.req = 4'b0011;
    bus.out_ready = 1'b1;
    #1;
    chk_out("burst_idle0", 4'b0000, 2'd0, 1'b0, 4'h0);
    tick();
`ifdef MUX4_ARB_BURST_LIMIT_EN
    for (int b = 0; b < 4; b++) begin
      chk_out($sformatf("burst_r0_b%0d", b), 4'b0001, 2'd0, 1'b1, 4'h5);
      tick();
    end
    chk_out("burst_turn", 4'b0000, 2'd0, 1'b0, 4'h0);
    tick();
    for (int b = 0; b < 4; b++) begin
      chk_out($sformatf("burst_r1_b%0d", b), 4'b0010, 2'd1, 1'b1, 4'hA);
      tick();
    end
    bus.req = 4'b0000;
    #1;
    chk_out("burst_end", 4'b0000, 2'd0, 1'b0, 4'h0);
    tick();
    exp_xfers = 7 + 8;
`else
    for (int b = 0; b < 12; b++) begin
      chk_out($sformatf("hold_r0_b%0d", b), 4'b0001, 2'd0, 1'b1, 4'h5);
      tick();
    end
    bus.req = 4'b0000;
    #1;
    chk_out("hold_drop", 4'b0001, 2'd0, 1'b0, 4'h0);
    tick();
    chk_out("hold_idle", 4'b0000, 2'd0, 1'b0, 4'h0);
    tick();
    exp_xfers = 7 + 12;
`endif
    chk("xfers_burst", 32'(xfers), 32'(exp_xfers));

    // Async reset mid-burst: outputs clear between edges, pointer returns to requester 0.
    bus.req = 4'b0100;
    #1;
    chk_out("ar_idle", 4'b0000, 2'd0, 1'b0, 4'h0);
    tick();
    chk_out("ar_grant", 4'b0100, 2'd2, 1'b1, 4'hC);
    rst_n = 1'b0;
    #1;
    chk_out("ar_clear", 4'b0000, 2'd0, 1'b0, 4'h0);
    chk("ar_sel", 32'({bus.s1, bus.s0}), 32'd0);
    bus.req = 4'b1111;
    #1;
    rst_n = 1'b1;
    tick();
    chk_out("ar_regrant", 4'b0001, 2'd0, 1'b1, 4'h5);
    chk("xfers_ar", 32'(xfers), 32'(exp_xfers));

    bus.req = 4'b0000;
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
